// File: rtl/adma_pkg.sv
// Shared ADMA constants, word type and width helper.
package adma_pkg;

  localparam int ADMA_DATA_WIDTH = 32;
  localparam int ADMA_FIFO_DEPTH = 16;

  typedef logic [ADMA_DATA_WIDTH-1:0] adma_word_t;

  // Smallest r with (1 << r) >= value; value 1 yields 0.
  function automatic int adma_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adma_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
module adma_fifo_mem
  import adma_pkg::*;
#(
  parameter int DATA_WIDTH = ADMA_DATA_WIDTH,
  parameter int DEPTH      = ADMA_FIFO_DEPTH,
  parameter int AW         = adma_clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately left unreset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/adma_data_fifo.sv
// First-word-fall-through buffer between the ADMA engine and the SD DAT serdes.
// Define ADMA_FIFO_ERR_EN to add sticky overflow/underflow flags.
module adma_data_fifo
  import adma_pkg::*;
#(
  parameter int DATA_WIDTH = ADMA_DATA_WIDTH,
  parameter int DEPTH      = ADMA_FIFO_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        clear,
  input  logic                        fifo_write,
  input  logic [DATA_WIDTH-1:0]       data_to_fifo,
  input  logic                        fifo_read,
  output logic [DATA_WIDTH-1:0]       data_from_fifo,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic                        almost_full,
  output logic                        almost_empty,
`ifdef ADMA_FIFO_ERR_EN
  output logic                        overflow,
  output logic                        underflow,
`endif
  output logic [adma_clog2(DEPTH):0]  fifo_count
);

  localparam int AW = adma_clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] head_word;

  // Flags come only from the registered count, never from the request inputs.
  assign fifo_full    = (count_q == CW'(DEPTH));
  assign fifo_empty   = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign fifo_count   = count_q;

  assign wr_acc = fifo_write & (~fifo_full | fifo_read);
  assign rd_acc = fifo_read & ~fifo_empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
      else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  adma_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (wr_acc & ~clear),
    .waddr_i (wptr_q),
    .wdata_i (data_to_fifo),
    .raddr_i (rptr_q),
    .rdata_o (head_word)
  );

  // Output reads as zero while empty so stale storage is never exposed.
  assign data_from_fifo = fifo_empty ? '0 : head_word;

`ifdef ADMA_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q | (fifo_write & fifo_full & ~fifo_read);
    unf_d = unf_q | (fifo_read & fifo_empty);
    if (clear) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_adma_data_fifo.sv
// Directed self-checking bench for adma_data_fifo (default 32x16 configuration).
module tb_adma_data_fifo;

  logic        CLK;
  logic        RESET;
  logic        clear;
  logic        fifo_write;
  logic [31:0] data_to_fifo;
  logic        fifo_read;
  logic [31:0] data_from_fifo;
  logic        fifo_full;
  logic        fifo_empty;
  logic        almost_full;
  logic        almost_empty;
  logic [4:0]  fifo_count;
`ifdef ADMA_FIFO_ERR_EN
  logic        overflow;
  logic        underflow;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  adma_data_fifo dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .clear          (clear),
    .fifo_write     (fifo_write),
    .data_to_fifo   (data_to_fifo),
    .fifo_read      (fifo_read),
    .data_from_fifo (data_from_fifo),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
`ifdef ADMA_FIFO_ERR_EN
    .overflow       (overflow),
    .underflow      (underflow),
`endif
    .fifo_count     (fifo_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    fifo_write   = 1'b0;
    fifo_read    = 1'b0;
    clear        = 1'b0;
    data_to_fifo = '0;
  endtask

  initial begin
    int tx;
    int rx;
    int gap;
    int guard;

    RESET = 1'b1;
    idle();
    cyc();
    cyc();
    RESET = 1'b0;

    // Reset state
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", data_from_fifo, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
`ifdef ADMA_FIFO_ERR_EN
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
`endif
    cyc();
    chk("idle_count", fifo_count, 0);

    // Fill to 16, watching thresholds
    for (int i = 0; i < 16; i++) begin
      fifo_write   = 1'b1;
      data_to_fifo = 32'h1000 + i;
      cyc();
      chk("fill_count", fifo_count, i + 1);
      chk("fill_af", almost_full, (i + 1) >= 14);
      chk("fill_ae", almost_empty, (i + 1) <= 2);
      chk("fill_head", data_from_fifo, 32'h1000);
      chk("fill_full", fifo_full, (i + 1) == 16);
    end
    data_to_fifo = 32'hDEAD;
    cyc();
    fifo_write = 1'b0;
    chk("ovf_count", fifo_count, 16);
    chk("ovf_full", fifo_full, 1);
    chk("ovf_head", data_from_fifo, 32'h1000);
`ifdef ADMA_FIFO_ERR_EN
    chk("ovf_flag", overflow, 1);
`endif
    fifo_read = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("pop_data", data_from_fifo, 32'h1000 + i);
      cyc();
      chk("pop_count", fifo_count, 15 - i);
    end
    fifo_read = 1'b0;
    chk("pop_empty", fifo_empty, 1);
    chk("pop_data0", data_from_fifo, 0);

    // Full with simultaneous read/write for 40 cycles
    for (int i = 0; i < 16; i++) begin
      fifo_write   = 1'b1;
      data_to_fifo = 32'h2000 + i;
      cyc();
    end
    chk("rw_full_pre", fifo_full, 1);
    fifo_read = 1'b1;
    for (int k = 0; k < 40; k++) begin
      data_to_fifo = 32'h2010 + k;
      chk("rw_data", data_from_fifo, 32'h2000 + k);
      cyc();
      chk("rw_count", fifo_count, 16);
    end
    fifo_write = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("rw_drain", data_from_fifo, 32'h2000 + 40 + i);
      cyc();
    end
    fifo_read = 1'b0;
    chk("rw_empty", fifo_empty, 1);

    // Read and write together while empty
    fifo_write   = 1'b1;
    fifo_read    = 1'b1;
    data_to_fifo = 32'hABCD;
    chk("e_rw_nobypass", data_from_fifo, 0);
    cyc();
    idle();
    chk("e_rw_count", fifo_count, 1);
    chk("e_rw_data", data_from_fifo, 32'hABCD);
    fifo_read = 1'b1;
    cyc();
    chk("e_pop_empty", fifo_empty, 1);
    cyc();
    fifo_read = 1'b0;
    chk("unf_count", fifo_count, 0);
`ifdef ADMA_FIFO_ERR_EN
    chk("unf_flag", underflow, 1);
`endif

    // Clear with a concurrent write at count 7
    for (int i = 0; i < 7; i++) begin
      fifo_write   = 1'b1;
      data_to_fifo = 32'h3000 + i;
      cyc();
    end
    chk("clr_pre", fifo_count, 7);
    clear        = 1'b1;
    data_to_fifo = 32'h7777;
    cyc();
    idle();
    chk("clr_count", fifo_count, 0);
    chk("clr_empty", fifo_empty, 1);
    chk("clr_data", data_from_fifo, 0);
`ifdef ADMA_FIFO_ERR_EN
    chk("clr_ovf", overflow, 0);
    chk("clr_unf", underflow, 0);
`endif
    fifo_write   = 1'b1;
    data_to_fifo = 32'h4444;
    cyc();
    idle();
    chk("clr_after_head", data_from_fifo, 32'h4444);
    chk("clr_after_cnt", fifo_count, 1);
    fifo_read = 1'b1;
    cyc();
    idle();

    // Asynchronous reset mid-stream at count 5
    for (int i = 0; i < 5; i++) begin
      fifo_write   = 1'b1;
      data_to_fifo = 32'h6000 + i;
      cyc();
    end
    chk("arst_pre", fifo_count, 5);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_async_cnt", fifo_count, 0);
    chk("arst_async_data", data_from_fifo, 0);
    cyc();
    RESET = 1'b0;
    idle();
    cyc();
    chk("arst_count", fifo_count, 0);
    chk("arst_empty", fifo_empty, 1);

    // Engine-style stream with random gaps
    tx = 0;
    rx = 0;
    gap = $urandom_range(0, 3);
    guard = 0;
    while ((rx < 64) && (guard < 3000)) begin
      guard++;
      fifo_read  = !fifo_empty;
      fifo_write = 1'b0;
      if (tx < 64) begin
        if (gap == 0) begin
          fifo_write   = 1'b1;
          data_to_fifo = 32'h5000 + tx;
        end else begin
          gap--;
        end
      end
      if (fifo_read) begin
        chk("strm_data", data_from_fifo, 32'h5000 + rx);
        rx++;
      end
      if (fifo_write && (!fifo_full || fifo_read)) begin
        tx++;
        gap = $urandom_range(0, 3);
      end
      cyc();
      chk("strm_le16", fifo_count <= 5'd16, 1);
    end
    idle();
    chk("strm_rx", rx, 64);
    chk("strm_end_empty", fifo_empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
